control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
- Parametrised, sequenced successor to the single-cycle nic8 control decoder.
- Owns the instruction register, a FETCH/EXEC/HALT state machine, a memory wait handshake and latched zero/carry flags.
- Emits per-cycle load enables and active-low bus-source selects.
- Sits between the memory/bus fabric and the register file + ALU. Field widths and source/dest counts are parameters, so the same block serves wider nic-family cores.

Parameters:
- IR_W, 8, instruction width. Must satisfy IR_W >= 2+SRC_W+DST_W. Layout is {cond[1:0], source, dest} in the top bits; any remaining low bits are ignored.
- SRC_W, 3, source field width. NSRC = 2**SRC_W.
- DST_W, 3, dest field width. NDST = 2**DST_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- irIn  in  IR_W  instruction byte from bus (ROM) during FETCH
- memReady  in  1  memory completes the current ROM/RAM access this cycle
- aluZero  in  1  ALU result == 0 (combinational from ALU)
- aluCarry  in  1  ALU carry-out
- ir  out  IR_W  current instruction register
- assertBar  out  NSRC  active-low one-cold bus-source select; bit 0 = ROM, 1 = RAM, 2 = A, 3 = X, 4 = E (ALU)
- loadEn  out  NDST  active-high one-cycle load strobes; bit 1 = PC, 2 = A, 3 = B, 4 = X, 6 = Q
- storeMem  out  1  RAM write request, held for the whole access
- pcInc  out  1  one-cycle PC increment pulse
- doSubtract  out  1  = ir cond[0]
- doJump  out  1  PC load taken
- flagZero, flagCarry  out  1 each  latched flags
- halted  out  1  HALT state

Behaviour:
- Reset values:
  - state=FETCH, ir=0, flags=0.
  - All loadEn=0, storeMem=0, pcInc=0, doJump=0, halted=0.
  - assertBar is all ones except during FETCH (see below).
  - A reset takes effect at any point, including mid-WAIT and in HALT. No strobe fires in the reset cycle.
- Memory access: mem = (source==1) or (dest==5); otherwise access is not a memory access.
- FETCH:
  - assertBar[0]=0.
  - When memReady=1: ir<=irIn, pcInc=1 for that cycle, next state EXEC.
  - While memReady=0: stay in FETCH with no pulses.
- EXEC:
  - assertBar[source]=0 (sources 5..NSRC-1 assert nothing). storeMem=(dest==5).
  - The instruction completes when memReady=1 or access is not a memory access. Only in the completing cycle do the following happen:
    - loadEn[dest]=1 for dest in {2,3,4,6}.
    - For dest==1: loadEn[1]=doJump=jc, where jc=(cond[1]&flagCarry)|(cond[0]&flagZero)|(cond==3).
    - Next state FETCH.
  - Stalled EXEC holds assertBar/storeMem stable and pulses nothing.
  - dest==0 in EXEC is a NOP.
- Flags:
  - Flags update only on a completing EXEC with dest==2 and source==4: flagZero<=aluZero, flagCarry<=aluCarry.
  - Otherwise the flags hold.
  - A jump reads the flags as they were before its own edge.
- HALT:
  - ir with source==NSRC-1 and dest==NDST-1 enters HALT at completion instead of FETCH.
  - In HALT: halted=1, all selects deasserted, no pulses. Exit only by reset.
- Outputs are registered-state decodes: combinational from state/ir/flags/memReady, with no path from irIn to the outputs.
- Latency:
  - A non-memory instruction takes 2 cycles (FETCH+EXEC) when ROM is ready.
  - Each memReady=0 cycle adds one cycle.

Decomposition:
- Package nic8_ctrl_pkg holds:
  - The state enum (FETCH, EXEC, HALT).
  - Source indices SRC_ROM/RAM/A/X/E.
  - Dest indices DST_IR/PC/A/B/X/MEM/Q.
  - Cond bit positions.
- Sub-module ctrl_decode: purely combinational, parametrised by IR_W/SRC_W/DST_W. Takes ir and flags; produces the field split, one-cold source select, one-hot dest decode and jc.
- control_seq instantiates ctrl_decode and holds the FSM, ir and flags.

Test Plan:
- Reset then ROM ready: reset=1 for 2 cycles, then memReady=1 with irIn=8'h22 (src=4, dst=2) and aluZero=1, aluCarry=0.
  - Cycle 1: pcInc=1 and ir becomes 22.
  - Cycle 2: assertBar=8'hEF, loadEn[2]=1, then flagZero=1.
- RAM stall: irIn=8'h0A (src=1, dst=2), memReady low for 3 EXEC cycles.
  - assertBar[1]=0 held for 4 cycles.
  - loadEn[2] pulses only in the 4th cycle, then the FSM returns to FETCH.
- Conditional jump: with flagZero=1, flagCarry=0, run irIn=8'h41, 8'h81, 8'hC1.
  - 41: doJump=1. 81: doJump=0 with no loadEn[1]. C1: doJump=1.
- Store: irIn=8'h15 (src=2, dst=5) with memReady=0,0,1.
  - storeMem=1 for 3 cycles and assertBar[2]=0 for 3 cycles. No loadEn pulses.
- Halt and reset mid-operation:
  - irIn=8'h3F: halted=1 and stays 1 for 10 cycles with no strobes.
  - Separately, assert reset during a stalled RAM EXEC: the next cycle shows state FETCH with zero strobes and flags cleared.
- Parameter sweep: IR_W=10, SRC_W=4, DST_W=4, with a halt opcode of src=15, dst=15.
  - halted=1.
  - The one-cold/one-hot properties of assertBar and loadEn hold in every cycle, checked by assertion.

Source files
------------

// File: rtl/nic8_ctrl_pkg.sv
// nic8_ctrl_pkg: shared state encoding and field indices for the nic8 sequenced controller
package nic8_ctrl_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  localparam int SRC_ROM = 0, SRC_RAM = 1, SRC_A = 2, SRC_X = 3, SRC_E = 4;
  localparam int DST_IR = 0, DST_PC = 1, DST_A = 2, DST_B = 3, DST_X = 4, DST_MEM = 5, DST_Q = 6;
  localparam int COND_Z = 0, COND_C = 1;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational split of the instruction register into selects, dest strobes and jump condition
module ctrl_decode
  import nic8_ctrl_pkg::*;
#(
  parameter int IR_W = 8,
  parameter int SRC_W = 3,
  parameter int DST_W = 3,
  localparam int NSRC = 2 ** SRC_W,
  localparam int NDST = 2 ** DST_W
) (
  input  logic [IR_W-1:0] ir,
  input  logic            flag_zero,
  input  logic            flag_carry,
  output logic [NSRC-1:0] src_sel,
  output logic [NDST-1:0] dst_oh,
  output logic            mem,
  output logic            hlt,
  output logic            alu_to_a,
  output logic            sub,
  output logic            jc
);
  localparam int FW = 2 + SRC_W + DST_W;
  logic [1:0] cond;
  logic [SRC_W-1:0] src;
  logic [DST_W-1:0] dst;
  logic [NSRC-1:0] src_oh, sel_mask;
  always_comb begin
    {cond, src, dst} = ir[IR_W-1 -: FW];
    src_oh = NSRC'(1) << src;
    dst_oh = NDST'(1) << dst;
    sel_mask = '0;
    sel_mask[SRC_E:SRC_ROM] = '1;
    src_sel = ~(src_oh & sel_mask);
    mem = src_oh[SRC_RAM] | dst_oh[DST_MEM];
    hlt = &{src, dst};
    alu_to_a = src_oh[SRC_E] & dst_oh[DST_A];
    sub = cond[COND_Z];
    jc = (cond[COND_C] & flag_carry) | (cond[COND_Z] & flag_zero) | (&cond);
  end
  if (IR_W > FW) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^ir[IR_W-FW-1:0];
  end
endmodule

// File: rtl/control_seq.sv
// control_seq: FETCH/EXEC/HALT sequencer owning the instruction register and latched ALU flags
module control_seq
  import nic8_ctrl_pkg::*;
#(
  parameter int IR_W = 8,
  parameter int SRC_W = 3,
  parameter int DST_W = 3,
  localparam int NSRC = 2 ** SRC_W,
  localparam int NDST = 2 ** DST_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] irIn,
  input  logic            memReady,
  input  logic            aluZero,
  input  logic            aluCarry,
  output logic [IR_W-1:0] ir,
  output logic [NSRC-1:0] assertBar,
  output logic [NDST-1:0] loadEn,
  output logic            storeMem,
  output logic            pcInc,
  output logic            doSubtract,
  output logic            doJump,
  output logic            flagZero,
  output logic            flagCarry,
  output logic            halted
);
  state_t state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic zf_q, zf_d, cf_q, cf_d;
  logic [NSRC-1:0] src_sel;
  logic [NDST-1:0] dst_oh, ld_mask;
  logic mem, hlt, alu_to_a, sub, jc, in_fetch, in_exec, done, go;
  ctrl_decode #(.IR_W(IR_W), .SRC_W(SRC_W), .DST_W(DST_W)) u_dec (
    .ir(ir_q), .flag_zero(zf_q), .flag_carry(cf_q), .src_sel(src_sel), .dst_oh(dst_oh),
    .mem(mem), .hlt(hlt), .alu_to_a(alu_to_a), .sub(sub), .jc(jc)
  );
  // strobes are gated by reset so nothing fires in the cycle a reset lands
  always_comb begin
    in_fetch = state_q == FETCH;
    in_exec = state_q == EXEC;
    done = in_exec & (memReady | ~mem);
    go = done & ~reset;
    state_d = state_q == HALT ? HALT : in_fetch ? (memReady ? EXEC : FETCH) : done ? (hlt ? HALT : FETCH) : EXEC;
    ir_d = in_fetch & memReady ? irIn : ir_q;
    zf_d = done & alu_to_a ? aluZero : zf_q;
    cf_d = done & alu_to_a ? aluCarry : cf_q;
    ld_mask = '0;
    ld_mask[DST_A] = 1'b1;
    ld_mask[DST_B] = 1'b1;
    ld_mask[DST_X] = 1'b1;
    ld_mask[DST_Q] = 1'b1;
    assertBar = in_fetch ? ~NSRC'(1) : in_exec ? src_sel : '1;
    doJump = go & dst_oh[DST_PC] & jc;
    loadEn = ({NDST{go}} & dst_oh & ld_mask) | (NDST'(doJump) << DST_PC);
    storeMem = in_exec & dst_oh[DST_MEM] & ~reset;
    pcInc = in_fetch & memReady & ~reset;
    halted = state_q == HALT;
    ir = ir_q;
    doSubtract = sub;
    flagZero = zf_q;
    flagCarry = cf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q <= '0;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      zf_q <= zf_d;
      cf_q <= cf_d;
    end
  end
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scoreboard bench for control_seq with directed per-cycle expectations
module tb_control_seq;
  typedef struct packed {
    logic chk;
    logic [7:0] ab, le;
    logic sm, pc, dj, ds, fz, fc, h;
    logic [7:0] ir;
  } exp_t;
  logic clk = 0, reset = 1, memReady = 0, aluZero = 0, aluCarry = 0;
  logic [7:0] irIn = 0, ir, assertBar, loadEn;
  logic storeMem, pcInc, doSubtract, doJump, flagZero, flagCarry, halted;
  logic [9:0] irIn2 = 10'h0FF, ir2;
  logic [15:0] assertBar2, loadEn2;
  logic storeMem2, pcInc2, doSubtract2, doJump2, flagZero2, flagCarry2, halted2;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  localparam exp_t SKIP = '0;
  always #5 clk = ~clk;
  control_seq dut (
    .clk(clk), .reset(reset), .irIn(irIn), .memReady(memReady), .aluZero(aluZero), .aluCarry(aluCarry),
    .ir(ir), .assertBar(assertBar), .loadEn(loadEn), .storeMem(storeMem), .pcInc(pcInc),
    .doSubtract(doSubtract), .doJump(doJump), .flagZero(flagZero), .flagCarry(flagCarry), .halted(halted)
  );
  control_seq #(.IR_W(10), .SRC_W(4), .DST_W(4)) dut2 (
    .clk(clk), .reset(reset), .irIn(irIn2), .memReady(memReady), .aluZero(1'b0), .aluCarry(1'b0),
    .ir(ir2), .assertBar(assertBar2), .loadEn(loadEn2), .storeMem(storeMem2), .pcInc(pcInc2),
    .doSubtract(doSubtract2), .doJump(doJump2), .flagZero(flagZero2), .flagCarry(flagCarry2), .halted(halted2)
  );
  function automatic exp_t mk(logic [7:0] ab, le, logic sm, pc, dj, fz, fc, h, logic [7:0] i);
    mk = '{1'b1, ab, le, sm, pc, dj, i[6], fz, fc, h, i};
  endfunction
  task automatic step(input logic r, input logic [7:0] i, input logic m, z, c, input exp_t e);
    reset = r; irIn = i; memReady = m; aluZero = z; aluCarry = c;
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      cyc++;
      a = '{1'b1, assertBar, loadEn, storeMem, pcInc, doJump, doSubtract, flagZero, flagCarry, halted, ir};
      if (e.chk) begin
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cyc%0d: got %h expected %h", cyc, a, e);
        end
      end
    end
    if (!reset) begin
      checks++;
      assert ($onehot0(~assertBar) && $onehot0(loadEn) && $onehot0(~assertBar2) && $onehot0(loadEn2))
      else begin
        errors++;
        $display("FAIL onehot: bar=%h le=%h bar2=%h le2=%h", assertBar, loadEn, assertBar2, loadEn2);
      end
    end
  end
  initial begin
    @(posedge clk); #1;
    step(1, 8'h00, 0, 0, 0, SKIP);
    step(1, 8'h00, 0, 1, 0, mk(8'hFE, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    step(0, 8'h22, 1, 1, 0, mk(8'hFE, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    step(0, 8'h00, 1, 1, 0, mk(8'hEF, 8'h04, 0, 0, 0, 0, 0, 0, 8'h22));
    step(0, 8'h0A, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0, 0, 8'h22));
    repeat (3) step(0, 8'h00, 0, 0, 0, mk(8'hFD, 8'h00, 0, 0, 0, 1, 0, 0, 8'h0A));
    step(0, 8'h00, 1, 0, 0, mk(8'hFD, 8'h04, 0, 0, 0, 1, 0, 0, 8'h0A));
    step(0, 8'h41, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0, 0, 8'h0A));
    step(0, 8'h00, 1, 0, 0, mk(8'hFE, 8'h02, 0, 0, 1, 1, 0, 0, 8'h41));
    step(0, 8'h81, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0, 0, 8'h41));
    step(0, 8'h00, 1, 0, 0, mk(8'hFE, 8'h00, 0, 0, 0, 1, 0, 0, 8'h81));
    step(0, 8'hC1, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0, 0, 8'h81));
    step(0, 8'h00, 1, 0, 0, mk(8'hFE, 8'h02, 0, 0, 1, 1, 0, 0, 8'hC1));
    step(0, 8'h15, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0, 0, 8'hC1));
    repeat (2) step(0, 8'h00, 0, 0, 0, mk(8'hFB, 8'h00, 1, 0, 0, 1, 0, 0, 8'h15));
    step(0, 8'h00, 1, 0, 0, mk(8'hFB, 8'h00, 1, 0, 0, 1, 0, 0, 8'h15));
    step(0, 8'h22, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 1, 0, 0, 8'h15));
    step(0, 8'h00, 1, 0, 1, mk(8'hEF, 8'h04, 0, 0, 0, 1, 0, 0, 8'h22));
    step(0, 8'h81, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 0, 1, 0, 8'h22));
    step(0, 8'h00, 1, 0, 0, mk(8'hFE, 8'h02, 0, 0, 1, 0, 1, 0, 8'h81));
    step(0, 8'h0A, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 0, 1, 0, 8'h81));
    step(0, 8'h00, 0, 0, 0, mk(8'hFD, 8'h00, 0, 0, 0, 0, 1, 0, 8'h0A));
    step(1, 8'h00, 0, 0, 0, mk(8'hFD, 8'h00, 0, 0, 0, 0, 1, 0, 8'h0A));
    step(0, 8'h00, 0, 0, 0, mk(8'hFE, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00));
    step(0, 8'h3F, 1, 0, 0, mk(8'hFE, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    step(0, 8'h00, 1, 0, 0, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3F));
    repeat (10) step(0, 8'h22, 1, 1, 1, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0, 1, 8'h3F));
    step(1, 8'h00, 1, 0, 0, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0, 1, 8'h3F));
    repeat (3) step(0, 8'h00, 1, 0, 0, SKIP);
    checks++;
    if (halted2 !== 1'b1 || loadEn2 !== 16'h0 || assertBar2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wide_halt: halted=%b le=%h bar=%h expected 1 0000 ffff", halted2, loadEn2, assertBar2);
    end
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
